// File: rtl/multicycle_control_fsm_if.sv
// Shared instruction/data memory handshake between the control FSM
// (master) and the memory port (slave).
interface multicycle_control_fsm_if;
    logic mem_req;
    logic mem_ready;
    logic MemRead;
    logic MemToWrite;

    modport master (
        output mem_req,
        output MemRead,
        output MemToWrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  MemRead,
        input  MemToWrite,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB with memory timeout.
// Define MC_RETIRE_CNT_EN to add the 16-bit retired-instruction counter port.
module multicycle_control_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master mem,
    input  logic [5:0]               op,
    input  logic                     zero,
    output logic                     MemToReg,
    output logic [2:0]               ALUOp,
    output logic                     RegWrite,
    output logic                     PCWrite,
    output logic                     PCSrc,
    output logic                     IRWrite,
    output logic                     illegal,
    output logic                     mem_err,
    output logic [2:0]               state
`ifdef MC_RETIRE_CNT_EN
    ,
    output logic [15:0]              retired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [7:0] LP_WMAX = 8'(WAIT_MAX);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op_q;
    logic [7:0] r_cnt;
    logic       r_mem_err;

    logic       w_req, w_rd, w_wr, w_m2r, w_rw;
    logic       w_pcw, w_src, w_irw, w_ill, w_ret;
    logic [2:0] w_alu;
    logic       w_legal, w_timeout, w_abort;

    assign w_legal = (op == OP_R) || (op == OP_LW) ||
                     (op == OP_SW) || (op == OP_BEQ);
    // Ready in the cycle the counter sits at WAIT_MAX still wins.
    assign w_timeout = (r_cnt == LP_WMAX) && !mem.mem_ready;
    assign w_abort   = w_req && w_timeout;

    always_comb begin
        w_next = S_FETCH;
        w_req  = 1'b0;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_m2r  = 1'b0;
        w_rw   = 1'b0;
        w_pcw  = 1'b0;
        w_src  = 1'b0;
        w_irw  = 1'b0;
        w_ill  = 1'b0;
        w_ret  = 1'b0;
        w_alu  = 3'b000;
        unique case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                w_rd  = 1'b1;
                if (mem.mem_ready) begin
                    w_irw  = 1'b1;
                    w_pcw  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_ill = 1'b1;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    (r_op_q == OP_R): begin
                        w_alu  = 3'b010;
                        w_next = S_WB;
                    end
                    (r_op_q == OP_LW),
                    (r_op_q == OP_SW): begin
                        w_next = S_MEM;
                    end
                    (r_op_q == OP_BEQ): begin
                        w_alu = 3'b001;
                        w_src = 1'b1;
                        w_pcw = zero;
                        w_ret = 1'b1;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (r_op_q == OP_LW) begin
                    w_req = 1'b1;
                    w_rd  = 1'b1;
                    if (mem.mem_ready) begin
                        w_next = S_WB;
                    end else if (!w_timeout) begin
                        w_next = S_MEM;
                    end
                end else if (r_op_q == OP_SW) begin
                    w_req = 1'b1;
                    w_wr  = 1'b1;
                    if (mem.mem_ready) begin
                        w_ret = 1'b1;
                    end else if (!w_timeout) begin
                        w_next = S_MEM;
                    end
                end
            end
            S_WB: begin
                w_rw  = 1'b1;
                w_m2r = (r_op_q == OP_LW);
                w_ret = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_op_q    <= '0;
            r_cnt     <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= op;
            end
            r_cnt <= (w_req && !mem.mem_ready && !w_abort) ? r_cnt + 8'd1 : 8'd0;
            if (w_abort) begin
                r_mem_err <= 1'b1;
            end
        end
    end

`ifdef MC_RETIRE_CNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_ret) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign retired = r_retired;
`endif

    // Reset must silence every output, including the FETCH request.
    assign mem.mem_req    = w_req & ~reset;
    assign mem.MemRead    = w_rd  & ~reset;
    assign mem.MemToWrite = w_wr  & ~reset;
    assign MemToReg       = w_m2r & ~reset;
    assign ALUOp          = reset ? 3'b000 : w_alu;
    assign RegWrite       = w_rw  & ~reset;
    assign PCWrite        = w_pcw & ~reset;
    assign PCSrc          = w_src & ~reset;
    assign IRWrite        = w_irw & ~reset;
    assign illegal        = w_ill & ~reset;
    assign mem_err        = r_mem_err;
    assign state          = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed vector bench for multicycle_control_fsm (WAIT_MAX = 3).
// Output vector: {state, req, rd, wr, m2r, alu, rw, pcw, src, irw, ill, err}.
module tb_multicycle_control_fsm;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic        zero;
    logic        MemToReg;
    logic [2:0]  ALUOp;
    logic        RegWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic        IRWrite;
    logic        illegal;
    logic        mem_err;
    logic [2:0]  state;
`ifdef MC_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.WAIT_MAX(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem      (bus.master),
        .op       (op),
        .zero     (zero),
        .MemToReg (MemToReg),
        .ALUOp    (ALUOp),
        .RegWrite (RegWrite),
        .PCWrite  (PCWrite),
        .PCSrc    (PCSrc),
        .IRWrite  (IRWrite),
        .illegal  (illegal),
        .mem_err  (mem_err),
        .state    (state)
`ifdef MC_RETIRE_CNT_EN
        ,
        .retired  (retired)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] w_act;
    assign w_act = {state, bus.mem_req, bus.MemRead, bus.MemToWrite,
                    MemToReg, ALUOp, RegWrite, PCWrite, PCSrc,
                    IRWrite, illegal, mem_err};

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        r;
        logic [15:0] e;
    } vec_t;

    localparam logic [5:0] R  = 6'h00;
    localparam logic [5:0] LW = 6'h23;
    localparam logic [5:0] SW = 6'h2B;
    localparam logic [5:0] BQ = 6'h04;
    localparam logic [5:0] IL = 6'h3F;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [15:0] eo(
        input int st, input int req, input int rd, input int wr,
        input int m2r, input int alu, input int rw, input int pcw,
        input int src, input int irw, input int ill, input int err);
        return {3'(st), 1'(req), 1'(rd), 1'(wr), 1'(m2r), 3'(alu),
                1'(rw), 1'(pcw), 1'(src), 1'(irw), 1'(ill), 1'(err)};
    endfunction

    task automatic check(input logic [15:0] e, input string nm);
        n_vec++;
        if (w_act !== e) begin
            n_bad++;
            $display("FAIL %s: outputs got %h want %h", nm, w_act, e);
        end
    endtask

    task automatic cyc(input logic [5:0] o, input logic z, input logic r,
                       input logic [15:0] e, input string nm);
        @(negedge clk);
        op = o;
        zero = z;
        bus.mem_ready = r;
        #1;
        check(e, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        op = R;
        zero = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check(16'h0000, "reset_hold");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

`ifdef MC_RETIRE_CNT_EN
    task automatic check_ret(input logic [15:0] e, input string nm);
        n_vec++;
        if (retired !== e) begin
            n_bad++;
            $display("FAIL %s: retired got %0d want %0d", nm, retired, e);
        end
    endtask
`endif

    logic [15:0] F_OK, F_WT, DEC, DEC_IL, EX_A, EX_R, EX_B1, EX_B0;
    logic [15:0] M_LW, M_SW, WB_R, WB_L;
    vec_t tbl[25];

    initial begin
        reset = 1'b1;
        op = R;
        zero = 1'b0;
        bus.mem_ready = 1'b0;

        F_OK   = eo(0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        F_WT   = eo(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        DEC    = eo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        DEC_IL = eo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        EX_A   = eo(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        EX_R   = eo(2, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        EX_B1  = eo(2, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        EX_B0  = eo(2, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        M_LW   = eo(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        M_SW   = eo(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        WB_R   = eo(4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        WB_L   = eo(4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);

        // op changes after DECODE check that EXEC/MEM/WB use the latched copy
        tbl[0]  = '{R,  1'b0, 1'b1, F_OK};
        tbl[1]  = '{R,  1'b0, 1'b0, DEC};
        tbl[2]  = '{R,  1'b0, 1'b1, EX_R};
        tbl[3]  = '{R,  1'b0, 1'b0, WB_R};
        tbl[4]  = '{LW, 1'b0, 1'b1, F_OK};
        tbl[5]  = '{LW, 1'b0, 1'b0, DEC};
        tbl[6]  = '{R,  1'b0, 1'b0, EX_A};
        tbl[7]  = '{R,  1'b0, 1'b0, M_LW};
        tbl[8]  = '{R,  1'b0, 1'b0, M_LW};
        tbl[9]  = '{R,  1'b0, 1'b1, M_LW};
        tbl[10] = '{R,  1'b0, 1'b0, WB_L};
        tbl[11] = '{BQ, 1'b1, 1'b1, F_OK};
        tbl[12] = '{BQ, 1'b1, 1'b0, DEC};
        tbl[13] = '{BQ, 1'b1, 1'b0, EX_B1};
        tbl[14] = '{BQ, 1'b0, 1'b1, F_OK};
        tbl[15] = '{BQ, 1'b0, 1'b0, DEC};
        tbl[16] = '{BQ, 1'b0, 1'b0, EX_B0};
        tbl[17] = '{IL, 1'b0, 1'b1, F_OK};
        tbl[18] = '{IL, 1'b0, 1'b0, DEC_IL};
        tbl[19] = '{SW, 1'b0, 1'b1, F_OK};
        tbl[20] = '{SW, 1'b0, 1'b0, DEC};
        tbl[21] = '{BQ, 1'b0, 1'b0, EX_A};
        tbl[22] = '{BQ, 1'b0, 1'b1, M_SW};
        tbl[23] = '{R,  1'b0, 1'b0, F_WT};
        tbl[24] = '{R,  1'b0, 1'b1, F_OK};

        do_reset();
        for (int i = 0; i < 25; i++) begin
            cyc(tbl[i].op, tbl[i].z, tbl[i].r, tbl[i].e,
                $sformatf("tbl[%0d]", i));
        end
`ifdef MC_RETIRE_CNT_EN
        check_ret(16'd5, "ret_tbl");
`endif

        // lw: ready arrives exactly when the counter sits at WAIT_MAX
        do_reset();
        cyc(LW, 1'b0, 1'b1, F_OK, "bnd_fetch");
        cyc(LW, 1'b0, 1'b0, DEC,  "bnd_dec");
        cyc(R,  1'b0, 1'b0, EX_A, "bnd_exec");
        for (int i = 0; i < 3; i++) begin
            cyc(R, 1'b0, 1'b0, M_LW, $sformatf("bnd_wait%0d", i));
        end
        cyc(R, 1'b0, 1'b1, M_LW, "bnd_ready");
        cyc(R, 1'b0, 1'b0, WB_L, "bnd_wb");

        // sw: memory never answers, abort after the wait budget
        cyc(SW, 1'b0, 1'b1, F_OK, "to_fetch");
        cyc(SW, 1'b0, 1'b0, DEC,  "to_dec");
        cyc(SW, 1'b0, 1'b0, EX_A, "to_exec");
        for (int i = 0; i < 4; i++) begin
            cyc(SW, 1'b0, 1'b0, M_SW, $sformatf("to_wait%0d", i));
        end
        cyc(R, 1'b0, 1'b0, F_WT | 16'h1, "to_abort");
        cyc(R, 1'b0, 1'b1, F_OK | 16'h1, "post_fetch");
        cyc(R, 1'b0, 1'b0, DEC  | 16'h1, "post_dec");
        cyc(R, 1'b0, 1'b0, EX_R | 16'h1, "post_exec");
        cyc(R, 1'b0, 1'b0, WB_R | 16'h1, "post_wb");
        cyc(R, 1'b0, 1'b0, F_WT | 16'h1, "post_sticky");
`ifdef MC_RETIRE_CNT_EN
        check_ret(16'd2, "ret_abort");
`endif

        // reset asserted in the middle of an lw memory wait
        do_reset();
        cyc(LW, 1'b0, 1'b1, F_OK, "rm_fetch");
        cyc(LW, 1'b0, 1'b0, DEC,  "rm_dec");
        cyc(R,  1'b0, 1'b0, EX_A, "rm_exec");
        cyc(R,  1'b0, 1'b0, M_LW, "rm_mem");
        #1;
        reset = 1'b1;
        #1;
        check(16'h0000, "rm_async");
`ifdef MC_RETIRE_CNT_EN
        check_ret(16'd0, "ret_reset");
`endif
        @(posedge clk);
        #1;
        check(16'h0000, "rm_hold");
        reset = 1'b0;
        cyc(R, 1'b0, 1'b0, F_WT, "rm_restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
